// File: rtl/car_traffic_controller_pkg.sv
// Shared game constants: display timing, lane geometry, car table helpers
// and the car controller state encoding.
package car_traffic_controller_pkg;

    localparam int H_DISPLAY   = 640;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BACK      = 48;
    localparam int V_DISPLAY   = 480;
    localparam int V_FRONT     = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 33;

    localparam int NUM_CARS    = 8;
    localparam int COORD_W     = 10;
    localparam int LEVEL_W     = 4;
    localparam int SPEED_W     = 5;
    localparam int IDX_W       = 3;
    localparam int LANE_Y0     = 64;
    localparam int LANE_PITCH  = 48;
    localparam int X_PITCH     = 80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UPDATE = 2'd2
    } car_state_e;

    // Start-of-level position of car i along one axis.
    function automatic logic [COORD_W-1:0] lane_pos(input int unsigned i,
                                                    input int unsigned origin,
                                                    input int unsigned pitch);
        return COORD_W'(origin + i * pitch);
    endfunction

endpackage

// File: rtl/car_traffic_controller_if.sv
// Game-side bundle between the traffic controller and the level/display logic.
interface car_traffic_controller_if;
    import car_traffic_controller_pkg::*;

    logic               vsync;
    logic [LEVEL_W-1:0] current_level;
    logic               pause;
    logic [COORD_W-1:0] car_x_0, car_x_1, car_x_2, car_x_3;
    logic [COORD_W-1:0] car_x_4, car_x_5, car_x_6, car_x_7;
    logic [COORD_W-1:0] car_y_0, car_y_1, car_y_2, car_y_3;
    logic [COORD_W-1:0] car_y_4, car_y_5, car_y_6, car_y_7;
    logic               busy;

    modport master (
        output vsync, current_level, pause,
        input  car_x_0, car_x_1, car_x_2, car_x_3, car_x_4, car_x_5, car_x_6, car_x_7,
        input  car_y_0, car_y_1, car_y_2, car_y_3, car_y_4, car_y_5, car_y_6, car_y_7,
        input  busy
    );

    modport slave (
        input  vsync, current_level, pause,
        output car_x_0, car_x_1, car_x_2, car_x_3, car_x_4, car_x_5, car_x_6, car_x_7,
        output car_y_0, car_y_1, car_y_2, car_y_3, car_y_4, car_y_5, car_y_6, car_y_7,
        output busy
    );

endinterface

// File: rtl/car_traffic_controller_car_step.sv
// Combinational next-x for one car with horizontal wrap.
// CAR_ALTERNATE_DIR_EN: when defined, cars flagged move_left travel leftwards.
module car_step
    import car_traffic_controller_pkg::*;
#(
    parameter int H_DISP = car_traffic_controller_pkg::H_DISPLAY
) (
    input  logic [COORD_W-1:0] x,
    input  logic [SPEED_W-1:0] speed,
    input  logic               move_left,
    output logic [COORD_W-1:0] nx
);

    localparam logic [COORD_W:0] H_W = (COORD_W+1)'(H_DISP);

    logic [COORD_W:0] x_w_s;
    logic [COORD_W:0] spd_w_s;
    logic [COORD_W:0] res_s;

    assign x_w_s   = {1'b0, x};
    assign spd_w_s = {{(COORD_W+1-SPEED_W){1'b0}}, speed};

`ifdef CAR_ALTERNATE_DIR_EN
    // Left movers wrap from the left edge onto the right side of the screen.
    always_comb begin
        res_s = x_w_s + spd_w_s;
        if (move_left) begin
            if (x_w_s >= spd_w_s) begin
                res_s = x_w_s - spd_w_s;
            end else begin
                res_s = x_w_s + H_W - spd_w_s;
            end
        end else if (res_s >= H_W) begin
            res_s = res_s - H_W;
        end else begin
            res_s = res_s;
        end
    end
`else
    logic unused_move_left_s;
    assign unused_move_left_s = move_left;

    // Right movers wrap from the right edge back to x=0 side.
    always_comb begin
        res_s = x_w_s + spd_w_s;
        if (res_s >= H_W) begin
            res_s = res_s - H_W;
        end else begin
            res_s = res_s;
        end
    end
`endif

    assign nx = COORD_W'(res_s);

endmodule

// File: rtl/car_traffic_controller.sv
// Eight-car traffic controller: reloads the car table on level change and
// advances one car per cycle after each vsync tick. Honours CAR_ALTERNATE_DIR_EN.
module car_traffic_controller
    import car_traffic_controller_pkg::*;
#(
    parameter int H_DISPLAY  = car_traffic_controller_pkg::H_DISPLAY,
    parameter int BASE_SPEED = 1,
    parameter int LANE_Y0    = car_traffic_controller_pkg::LANE_Y0,
    parameter int LANE_PITCH = car_traffic_controller_pkg::LANE_PITCH,
    parameter int X_PITCH    = car_traffic_controller_pkg::X_PITCH
) (
    input  logic                     clk,
    input  logic                     reset,
    car_traffic_controller_if.slave  bus
);

    logic               vs_q,    vs_d;
    logic [LEVEL_W-1:0] lvl_q,   lvl_d;
    car_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               busy_q,  busy_d;
    logic [COORD_W-1:0] car_x_q [NUM_CARS];
    logic [COORD_W-1:0] car_x_d [NUM_CARS];
    logic [COORD_W-1:0] car_y_q [NUM_CARS];
    logic [COORD_W-1:0] car_y_d [NUM_CARS];

    logic               tick_s;
    logic               lvl_chg_s;
    logic               car_active_s;
    logic [SPEED_W-1:0] speed_s;
    logic [COORD_W-1:0] sel_x_s;
    logic [COORD_W-1:0] step_x_s;

    assign tick_s       = bus.vsync & ~vs_q;
    assign lvl_chg_s    = (bus.current_level != lvl_q);
    assign car_active_s = (bus.current_level > {1'b0, idx_q});
    assign speed_s      = SPEED_W'(BASE_SPEED) + {1'b0, bus.current_level};
    assign sel_x_s      = car_x_q[idx_q];

    car_step #(
        .H_DISP (H_DISPLAY)
    ) u_car_step (
        .x         (sel_x_s),
        .speed     (speed_s),
        .move_left (idx_q[0]),
        .nx        (step_x_s)
    );

    // Next-state and datapath: a level change overrides any idle or update work.
    always_comb begin
        vs_d    = bus.vsync;
        lvl_d   = lvl_q;
        state_d = state_q;
        idx_d   = idx_q;
        car_x_d = car_x_q;
        car_y_d = car_y_q;
        case (state_q)
            LOAD: begin
                for (int i = 0; i < NUM_CARS; i++) begin
                    car_x_d[i] = lane_pos(i, 0, X_PITCH);
                    car_y_d[i] = lane_pos(i, LANE_Y0, LANE_PITCH);
                end
                lvl_d   = bus.current_level;
                idx_d   = '0;
                state_d = IDLE;
            end
            IDLE: begin
                if (lvl_chg_s) begin
                    state_d = LOAD;
                end else if (tick_s && !bus.pause) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                if (lvl_chg_s) begin
                    state_d = LOAD;
                end else begin
                    if (car_active_s) begin
                        car_x_d[idx_q] = step_x_s;
                    end else begin
                        car_x_d[idx_q] = car_x_q[idx_q];
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        state_d = UPDATE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and car table registers; reset loads the level-0 table.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q    <= 1'b0;
            lvl_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x_q[i] <= lane_pos(i, 0, X_PITCH);
                car_y_q[i] <= lane_pos(i, LANE_Y0, LANE_PITCH);
            end
        end else begin
            vs_q    <= vs_d;
            lvl_q   <= lvl_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            car_x_q <= car_x_d;
            car_y_q <= car_y_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.car_x_0 = car_x_q[0];
    assign bus.car_x_1 = car_x_q[1];
    assign bus.car_x_2 = car_x_q[2];
    assign bus.car_x_3 = car_x_q[3];
    assign bus.car_x_4 = car_x_q[4];
    assign bus.car_x_5 = car_x_q[5];
    assign bus.car_x_6 = car_x_q[6];
    assign bus.car_x_7 = car_x_q[7];
    assign bus.car_y_0 = car_y_q[0];
    assign bus.car_y_1 = car_y_q[1];
    assign bus.car_y_2 = car_y_q[2];
    assign bus.car_y_3 = car_y_q[3];
    assign bus.car_y_4 = car_y_q[4];
    assign bus.car_y_5 = car_y_q[5];
    assign bus.car_y_6 = car_y_q[6];
    assign bus.car_y_7 = car_y_q[7];

endmodule

// File: tb/tb_car_traffic_controller.sv
// Randomized bench for car_traffic_controller against a frame-level reference model.
module tb_car_traffic_controller;

    logic clk;
    logic reset;
    car_traffic_controller_if bus ();

    car_traffic_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] dut_x [8];
    logic [9:0] dut_y [8];
    assign dut_x[0] = bus.car_x_0;  assign dut_y[0] = bus.car_y_0;
    assign dut_x[1] = bus.car_x_1;  assign dut_y[1] = bus.car_y_1;
    assign dut_x[2] = bus.car_x_2;  assign dut_y[2] = bus.car_y_2;
    assign dut_x[3] = bus.car_x_3;  assign dut_y[3] = bus.car_y_3;
    assign dut_x[4] = bus.car_x_4;  assign dut_y[4] = bus.car_y_4;
    assign dut_x[5] = bus.car_x_5;  assign dut_y[5] = bus.car_y_5;
    assign dut_x[6] = bus.car_x_6;  assign dut_y[6] = bus.car_y_6;
    assign dut_x[7] = bus.car_x_7;  assign dut_y[7] = bus.car_y_7;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: car table, level seen, previous vsync, pending reload,
    // and the next car due in the running frame sweep (-1 when none).
    int m_x [8];
    int m_y [8];
    int m_lvl;
    int m_vs;
    int m_load;
    int m_car;
    int m_busy;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_table();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = i * 80;
            m_y[i] = 64 + i * 48;
        end
    endtask

    function automatic int model_move(input int x, input int car, input int lvl);
        int spd;
        spd = 1 + lvl;
`ifdef CAR_ALTERNATE_DIR_EN
        if (car % 2 == 1) return (x + 640 - spd) % 640;
`endif
        return (x + spd) % 640;
    endfunction

    task automatic model_step();
        int tick;
        if (reset) begin
            model_table();
            m_lvl = 0; m_vs = 0; m_load = 0; m_car = -1;
        end else begin
            tick = (bus.vsync && !m_vs) ? 1 : 0;
            m_vs = int'(bus.vsync);
            if (m_load != 0) begin
                model_table();
                m_lvl = int'(bus.current_level);
                m_load = 0; m_car = -1;
            end else if (int'(bus.current_level) != m_lvl) begin
                m_load = 1; m_car = -1;
            end else if (m_car >= 0) begin
                if (m_lvl > m_car) m_x[m_car] = model_move(m_x[m_car], m_car, m_lvl);
                m_car++;
                if (m_car == 8) m_car = -1;
            end else if (tick != 0 && !bus.pause) begin
                m_car = 0;
            end
        end
        m_busy = (m_load != 0 || m_car >= 0) ? 1 : 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 8; i++) begin
            chk_eq($sformatf("car_x_%0d", i), int'(dut_x[i]), m_x[i]);
            chk_eq($sformatf("car_y_%0d", i), int'(dut_y[i]), m_y[i]);
        end
        chk_eq("busy", int'(bus.busy), m_busy);
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        cyc();
        bus.vsync = 1'b0;
        repeat (11) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
    endtask

    int busy_cnt;
    int before_x0;

    initial begin
        reset = 1'b1;
        bus.vsync = 1'b0;
        bus.current_level = 4'd0;
        bus.pause = 1'b0;
        model_table();
        m_lvl = 0; m_vs = 0; m_load = 0; m_car = -1; m_busy = 0;

        // Reset table and idle level 0 frames.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk_eq("rst_x", int'(dut_x[i]), i * 80);
            chk_eq("rst_y", int'(dut_y[i]), 64 + i * 48);
        end
        chk_eq("rst_busy", int'(bus.busy), 0);
        frame();
        chk_eq("lvl0_x7", int'(dut_x[7]), 560);

        // Level 0 -> 3: a single reload cycle, then two frames at speed 4.
        bus.current_level = 4'd3;
        busy_cnt = 0;
        repeat (5) begin
            cyc();
            busy_cnt += int'(bus.busy);
        end
        chk_eq("load_busy_cycles", busy_cnt, 1);
        frame();
        frame();
        chk_eq("l3_x0", int'(dut_x[0]), 8);
        chk_eq("l3_x1", int'(dut_x[1]), 88);
        chk_eq("l3_x2", int'(dut_x[2]), 168);
        chk_eq("l3_x3", int'(dut_x[3]), 240);

        // Paused frames: nothing moves, never busy.
        bus.pause = 1'b1;
        busy_cnt = 0;
        repeat (3) begin
            bus.vsync = 1'b1;
            cyc();
            busy_cnt += int'(bus.busy);
            bus.vsync = 1'b0;
            repeat (6) begin
                cyc();
                busy_cnt += int'(bus.busy);
            end
        end
        chk_eq("pause_busy", busy_cnt, 0);
        chk_eq("pause_x0", int'(dut_x[0]), 8);
        bus.pause = 1'b0;

        // Second vsync edge inside an update sweep is dropped.
        before_x0 = m_x[0];
        bus.vsync = 1'b1; cyc();
        bus.vsync = 1'b0; repeat (3) cyc();
        bus.vsync = 1'b1; cyc();
        bus.vsync = 1'b0; repeat (12) cyc();
        chk_eq("one_adv_x0", int'(dut_x[0]), (before_x0 + 4) % 640);

        // Level change while car 3 is being processed aborts to the reload.
        bus.vsync = 1'b1; cyc();
        bus.vsync = 1'b0; repeat (3) cyc();
        bus.current_level = 4'd5;
        cyc();
        chk_eq("abort_busy", int'(bus.busy), 1);
        cyc();
        for (int i = 0; i < 8; i++) chk_eq("abort_tbl_x", int'(dut_x[i]), i * 80);

        // Level 15: car 7 wraps after five frames and shows at tick+9.
        bus.current_level = 4'd15;
        repeat (3) cyc();
        repeat (5) frame();
        chk_eq("wrap_x7", int'(dut_x[7]), 0);
        bus.vsync = 1'b1; cyc();
        bus.vsync = 1'b0; repeat (7) cyc();
        chk_eq("lat_pre_x7", int'(dut_x[7]), 0);
        cyc();
        chk_eq("lat_post_x7", int'(dut_x[7]), 16);
        repeat (4) cyc();

        // Level 8 (speed 9) single frame; direction depends on build option.
        bus.current_level = 4'd8;
        repeat (3) cyc();
        frame();
        chk_eq("l8_x0", int'(dut_x[0]), 9);
`ifdef CAR_ALTERNATE_DIR_EN
        chk_eq("l8_x1", int'(dut_x[1]), 71);
`else
        chk_eq("l8_x1", int'(dut_x[1]), 89);
`endif

        // Random vsync / pause / level / reset traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.vsync = ($urandom_range(0, 3) == 0);
            bus.pause = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 79) == 0) bus.current_level = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0;
        bus.vsync = 1'b0;
        repeat (12) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/car_traffic_controller.md
CAR_TRAFFIC_CONTROLLER -- requirements
Module: car_traffic_controller

Interface
REQ-001 SHALL have parameter H_DISPLAY, 640, visible width in pixels and the horizontal wrap modulus.
REQ-002 SHALL have parameter BASE_SPEED, 1, pixels per frame added to the level-derived speed.
REQ-003 SHALL have parameter LANE_Y0, 64, y coordinate of lane 0.
REQ-004 SHALL have parameter LANE_PITCH, 48, y spacing between lanes.
REQ-005 SHALL have parameter X_PITCH, 80, initial x spacing between cars.
REQ-006 SHALL have port clk  in  1  single system clock (the same pixel clock as the display stage); all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port vsync  in  1  vertical sync from the display stage; its rising edge is the frame tick.
REQ-009 SHALL have port current_level  in  4  game level; car i is active iff current_level > i.
REQ-010 SHALL have port pause  in  1  high suppresses movement on frame ticks.
REQ-011 SHALL have ports car_x_0..car_x_7  out  10 each  car left edge, registered.
REQ-012 SHALL have ports car_y_0..car_y_7  out  10 each  car top edge, registered.
REQ-013 SHALL have port busy  out  1  high while a position update or reload is in progress.

Function
REQ-014 SHALL hold vsync in a register vs_q and detect the tick as vsync=1 & vs_q=0.
REQ-015 SHALL implement states IDLE, LOAD and UPDATE.
REQ-016 SHALL hold a registered copy lvl_q of current_level; any mismatch in any state SHALL enter LOAD the next cycle, and LOAD SHALL have priority over all else.
REQ-017 In LOAD, the block SHALL, in one cycle, set car_x_i = i*X_PITCH and car_y_i = LANE_Y0 + i*LANE_PITCH, copy current_level into lvl_q, then return to IDLE.
REQ-018 In IDLE, a tick with pause=0 SHALL enter UPDATE with idx=0; a tick with pause=1 SHALL be ignored.
REQ-019 In UPDATE, the block SHALL process car idx on each cycle (idx 0..7), 8 cycles in total, and SHALL return to IDLE after idx=7.
REQ-020 Speed SHALL be BASE_SPEED + current_level, computed 5 bits wide (max 16).
REQ-021 An active car SHALL get nx = x + speed, computed 11 bits wide; if nx >= H_DISPLAY then car_x SHALL become nx - H_DISPLAY, else nx.
REQ-022 An inactive car (current_level <= idx) SHALL hold its position.
REQ-023 car_y SHALL never change outside reset and LOAD.
REQ-024 busy SHALL be 1 in LOAD and in UPDATE, and 0 in IDLE.
REQ-025 A tick arriving during UPDATE or LOAD SHALL be dropped, not queued.
REQ-026 A pause change during UPDATE SHALL NOT abort the update.
REQ-027 A level change during UPDATE SHALL abort the update; cars already updated SHALL be overwritten by LOAD.
REQ-028 Latency: with the tick detected in cycle N, car i SHALL show its new value from cycle N+2+i, and busy SHALL be high for cycles N+1..N+8.

Reset
REQ-029 While reset=1, all registers SHALL take their LOAD values, with lvl_q=0, vs_q=0, state=IDLE, idx=0 and busy=0.
REQ-030 Reset SHALL win over any LOAD or UPDATE in progress; the first tick is honoured no earlier than the cycle after reset deasserts.

Configuration
REQ-031 With CAR_ALTERNATE_DIR_EN defined, odd-index cars SHALL move left: if x >= speed then x - speed, else x + H_DISPLAY - speed.
REQ-032 With CAR_ALTERNATE_DIR_EN defined, even-index cars SHALL be unchanged.
REQ-033 Without CAR_ALTERNATE_DIR_EN, all cars SHALL move right per REQ-021 and no left-move logic SHALL be synthesised.

Structure
REQ-034 H_DISPLAY, the lane geometry constants, car count 8, the 10-bit coordinate width and the state encoding SHALL live in the shared game package, together with the display stage's constants.
REQ-035 One sub-module car_step SHALL be used: combinational single-car next-x with wrap and direction; the controller instantiates it once and muxes it by idx.

Verification
REQ-036 Reset, then hold level=0 -> all car_x = 0,80,...,560; car_y = 64,112,...,400; busy=0.
REQ-037 Level 0->3 -> exactly one busy cycle (LOAD); after two ticks car_x_0=8, car_x_1=88, car_x_2=168 (speed 4); cars 3..7 unchanged.
REQ-038 Level=15 (speed 16), car_x_7=630 at tick -> car_x_7=6 (wrap), and it appears 9 cycles after the edge-detect cycle.
REQ-039 pause=1 across 3 ticks -> no position change and busy stays 0; a second vsync edge 4 cycles into UPDATE -> exactly one advance per car.
REQ-040 Level change in the cycle idx=3 -> LOAD the next cycle and all cars at initial table.
REQ-041 With CAR_ALTERNATE_DIR_EN and level=8 (speed 9): car_x_1=80 -> 71; car_x_3=5 -> 636; car_x_0=0 -> 9.
